// File: rtl/sub_box_arbiter.sv
// sub_box_arbiter
//
// Time-shares a single 32-bit SubBox between the round datapath and the key
// schedule.
// - Round datapath: a 128-bit SubBytes, done one word per cycle over four cycles.
// - Key schedule: a 32-bit SubWord, done in one cycle.
// Each cycle exactly one requester (or nobody) owns the S-box slot.
//
// Parameters:
//   KEY_PRIORITY  1: a pending key word takes the slot ahead of remaining state words
//                 0: a pending key word waits until no state block is in flight
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   st_valid   state request valid
//   st_ready   state request can be accepted
//   st_in      128-bit state; word i = bits [127-32i : 96-32i]
//   st_out     substituted state, same word order; holds until next completion
//   st_done    one-cycle pulse, st_out valid
//   key_valid  key-word request valid
//   key_ready  key request can be accepted
//   key_in     32-bit word to substitute
//   key_out    substituted word; holds until next completion
//   key_done   one-cycle pulse, key_out valid
//   sbox_in    drives SubBox.beforeSub
//   sbox_out   from SubBox.afterSub (combinational)

module sub_box_arbiter #(
    parameter bit KEY_PRIORITY = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_in,
    output logic [127:0] st_out,
    output logic         st_done,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [31:0]  key_in,
    output logic [31:0]  key_out,
    output logic         key_done,
    output logic [31:0]  sbox_in,
    input  logic [31:0]  sbox_out
);

    typedef enum logic [1:0] {
        SlotIdle,
        SlotKey,
        SlotState
    } slot_e;

    slot_e slot;

    logic [127:0] st_buf_q, st_buf_d;
    logic [127:0] st_acc_q, st_acc_d;
    logic [127:0] st_out_q, st_out_d;
    logic         st_busy_q, st_busy_d;
    logic [1:0]   idx_q, idx_d;
    logic         st_done_q, st_done_d;

    logic [31:0]  key_buf_q, key_buf_d;
    logic [31:0]  key_out_q, key_out_d;
    logic         key_pend_q, key_pend_d;
    logic         key_done_q, key_done_d;

    logic [31:0]  st_word;
    logic         st_take;
    logic         key_take;

    // Readiness is masked by reset so nothing is accepted in a reset cycle.
    assign st_ready  = !st_busy_q && !reset;
    assign key_ready = !key_pend_q && !reset;
    assign st_take   = st_valid && st_ready;
    assign key_take  = key_valid && key_ready;

    assign st_out   = st_out_q;
    assign st_done  = st_done_q;
    assign key_out  = key_out_q;
    assign key_done = key_done_q;

    // Slot grant and S-box input select.
    always_comb begin
        slot = SlotIdle;
        if (key_pend_q && (KEY_PRIORITY || !st_busy_q)) begin
            slot = SlotKey;
        end else if (st_busy_q) begin
            slot = SlotState;
        end

        st_word = 32'h0;
        unique case (idx_q)
            2'd0: st_word = st_buf_q[127:96];
            2'd1: st_word = st_buf_q[95:64];
            2'd2: st_word = st_buf_q[63:32];
            2'd3: st_word = st_buf_q[31:0];
            default: st_word = 32'h0;
        endcase

        sbox_in = 32'h0;
        unique case (slot)
            SlotKey:   sbox_in = key_buf_q;
            SlotState: sbox_in = st_word;
            default:   sbox_in = 32'h0;
        endcase
    end

    // Next-state logic. An accept and a slot for the same requester can never
    // coincide (accept needs the requester idle, a slot needs it busy), so the
    // two sections below never fight over a register.
    always_comb begin
        st_buf_d   = st_buf_q;
        st_acc_d   = st_acc_q;
        st_out_d   = st_out_q;
        st_busy_d  = st_busy_q;
        idx_d      = idx_q;
        st_done_d  = 1'b0;
        key_buf_d  = key_buf_q;
        key_out_d  = key_out_q;
        key_pend_d = key_pend_q;
        key_done_d = 1'b0;

        if (st_take) begin
            st_buf_d  = st_in;
            st_busy_d = 1'b1;
            idx_d     = 2'd0;
        end

        if (key_take) begin
            key_buf_d  = key_in;
            key_pend_d = 1'b1;
        end

        unique case (slot)
            SlotKey: begin
                // A preempted state block keeps idx and st_acc, resuming later.
                key_out_d  = sbox_out;
                key_done_d = 1'b1;
                key_pend_d = 1'b0;
            end
            SlotState: begin
                unique case (idx_q)
                    2'd0: st_acc_d[127:96] = sbox_out;
                    2'd1: st_acc_d[95:64]  = sbox_out;
                    2'd2: st_acc_d[63:32]  = sbox_out;
                    2'd3: st_acc_d[31:0]   = sbox_out;
                    default: st_acc_d = st_acc_q;
                endcase
                if (idx_q == 2'd3) begin
                    // Last word bypasses st_acc so st_out only ever sees whole blocks.
                    st_out_d  = {st_acc_q[127:32], sbox_out};
                    st_done_d = 1'b1;
                    st_busy_d = 1'b0;
                    idx_d     = 2'd0;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_buf_q   <= 128'h0;
            st_acc_q   <= 128'h0;
            st_out_q   <= 128'h0;
            st_busy_q  <= 1'b0;
            idx_q      <= 2'd0;
            st_done_q  <= 1'b0;
            key_buf_q  <= 32'h0;
            key_out_q  <= 32'h0;
            key_pend_q <= 1'b0;
            key_done_q <= 1'b0;
        end else begin
            st_buf_q   <= st_buf_d;
            st_acc_q   <= st_acc_d;
            st_out_q   <= st_out_d;
            st_busy_q  <= st_busy_d;
            idx_q      <= idx_d;
            st_done_q  <= st_done_d;
            key_buf_q  <= key_buf_d;
            key_out_q  <= key_out_d;
            key_pend_q <= key_pend_d;
            key_done_q <= key_done_d;
        end
    end

endmodule
